// File: rtl/miriscv_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Holds the datapath width, opcode encodings and FSM state type.
// Imported by the MDU and by the decoder that generates mdu_op_i.
package miriscv_mdu_pkg;

  localparam int XLEN     = 32;
  localparam int MDU_OP_W = 3;
  localparam int CNT_W    = $clog2(XLEN);

  // op[2] distinguishes divide-type from multiply-type operations,
  // and within the divides op[1] selects remainder over quotient.
  localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'd5;
  localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'd6;
  localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/miriscv_mdu.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide).
// Latency: valid XLEN+1 cycles after request; div-by-zero and signed overflow in 1 cycle.
// Backpressure: holds mdu_stall_req_o while a request is pending; kill aborts with no valid.
// Ports: clk_i/rstn_i (sync, active low); mdu_req_i, mdu_port_a_i, mdu_port_b_i, mdu_op_i,
//        mdu_kill_i in; mdu_stall_req_o (comb), mdu_valid_o, mdu_result_o (registered) out.
module miriscv_mdu
  import miriscv_mdu_pkg::*;
(
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                mdu_req_i,
  input  logic [XLEN-1:0]     mdu_port_a_i,
  input  logic [XLEN-1:0]     mdu_port_b_i,
  input  logic [MDU_OP_W-1:0] mdu_op_i,
  input  logic                mdu_kill_i,
  output logic                mdu_stall_req_o,
  output logic                mdu_valid_o,
  output logic [XLEN-1:0]     mdu_result_o
);

  mdu_state_e          state;
  logic [CNT_W-1:0]    count;
  // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opb_q;
  logic [MDU_OP_W-1:0] op_q;
  logic                neg_q;      // product or quotient must be negated
  logic                rem_neg_q;  // remainder takes the sign of a

  // ---------------- request decode ----------------
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  assign is_div   = mdu_op_i[2];
  assign a_signed = (mdu_op_i == MDU_MUL) || (mdu_op_i == MDU_MULH) ||
                    (mdu_op_i == MDU_MULHSU) || (mdu_op_i == MDU_DIV) ||
                    (mdu_op_i == MDU_REM);
  assign b_signed = (mdu_op_i == MDU_MUL) || (mdu_op_i == MDU_MULH) ||
                    (mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_REM);
  assign a_neg    = a_signed & mdu_port_a_i[XLEN-1];
  assign b_neg    = b_signed & mdu_port_b_i[XLEN-1];
  assign a_mag    = a_neg ? -mdu_port_a_i : mdu_port_a_i;
  assign b_mag    = b_neg ? -mdu_port_b_i : mdu_port_b_i;

  assign div_zero = is_div && (mdu_port_b_i == '0);
  assign div_ovf  = ((mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_REM)) &&
                    (mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (mdu_port_b_i == '1);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = mdu_op_i[1] ? mdu_port_a_i : '1;
    else if (div_ovf)
      special_res = mdu_op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // ---------------- one radix-2 step ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   div_trial;
  logic              div_ge;
  logic [2*XLEN-1:0] step_next;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + ({1'b0, opb_q} & {(XLEN+1){acc[0]}});
  // The shifted partial remainder is below 2*b, so 33 bits suffice for the compare
  // and the low XLEN bits of the difference are exact whenever it is kept.
  assign div_ge    = acc[2*XLEN-1:XLEN-1] >= {1'b0, opb_q};
  assign div_trial = acc[2*XLEN-2:XLEN-1] - opb_q;

  always_comb begin
    if (op_q[2])
      step_next = div_ge ? {div_trial, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    else
      step_next = {mul_sum, acc[XLEN-1:1]};
  end

  // ---------------- sign fix-up and result select ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   final_res;

  assign prod_fix = neg_q ? -step_next : step_next;

  always_comb begin
    final_res = '0;
    case (op_q)
      MDU_MUL:              final_res = prod_fix[XLEN-1:0];
      MDU_DIV, MDU_DIVU:    final_res = neg_q ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
      MDU_REM, MDU_REMU:    final_res = rem_neg_q ? -step_next[2*XLEN-1:XLEN]
                                                  : step_next[2*XLEN-1:XLEN];
      default:              final_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  assign mdu_stall_req_o = mdu_req_i & ~mdu_kill_i & (state != ST_DONE);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state        <= ST_IDLE;
      count        <= '0;
      acc          <= '0;
      opb_q        <= '0;
      op_q         <= MDU_MUL;
      neg_q        <= 1'b0;
      rem_neg_q    <= 1'b0;
      mdu_valid_o  <= 1'b0;
      mdu_result_o <= '0;
    end else if (mdu_kill_i) begin
      state       <= ST_IDLE;
      mdu_valid_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          mdu_valid_o <= 1'b0;
          if (mdu_req_i) begin
            if (div_zero || div_ovf) begin
              mdu_result_o <= special_res;
              mdu_valid_o  <= 1'b1;
              state        <= ST_DONE;
            end else begin
              acc       <= {{XLEN{1'b0}}, a_mag};
              opb_q     <= b_mag;
              op_q      <= mdu_op_i;
              neg_q     <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              count     <= CNT_W'(XLEN-1);
              state     <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc <= step_next;
          if (count == '0) begin
            mdu_result_o <= final_res;
            mdu_valid_o  <= 1'b1;
            state        <= ST_DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          // The request still held in DONE is the finished instruction.
          mdu_valid_o <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/miriscv_mdu.md
Name: miriscv_mdu

Overview:
Iterative multiply/divide unit for the RV32M extension. It sits in the execute stage beside the single-cycle ALU and receives the same operand pair plus its own opcode. Unlike the ALU, it is a multi-cycle responder. It stalls the pipeline through a request/stall/valid handshake until its registered result is ready.

Parameters:
XLEN, 32 (from miriscv_pkg), operand and result width.

Ports:
clk_i  in  1  core clock
rstn_i  in  1  synchronous reset, active low
mdu_req_i  in  1  operation request; held stable with operands and opcode until mdu_valid_o or mdu_kill_i
mdu_port_a_i  in  XLEN  first operand (rs1)
mdu_port_b_i  in  XLEN  second operand (rs2)
mdu_op_i  in  MDU_OP_W  opcode (MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU)
mdu_kill_i  in  1  flush; aborts the operation in flight
mdu_stall_req_o  out  1  pipeline stall request
mdu_valid_o  out  1  one-cycle result-valid pulse
mdu_result_o  out  XLEN  result; registered; meaningful only while mdu_valid_o is high

Behaviour:
- One clock domain. Reset is synchronous and active low: every flop takes its reset value on a clk_i edge while rstn_i=0.
- Reset values: state=IDLE, mdu_valid_o=0, mdu_result_o=0, count=0, internal accumulators=0. mdu_stall_req_o is therefore 0 unless mdu_req_i=1.
- FSM states are IDLE, CALC and DONE.
- IDLE with mdu_req_i=1 and mdu_kill_i=0, normal operation:
  - Latch the operand magnitudes, result-sign flags and opcode.
  - Load count=XLEN-1.
  - Go to CALC.
- IDLE with a special case (divide-type op with b=0, or DIV/REM with a=0x8000_0000 and b=0xFFFF_FFFF):
  - Load the result directly and go to DONE.
- CALC: one radix-2 step per cycle. When count=0 go to DONE; otherwise decrement count.
  - Multiply: shift-add on a 2*XLEN product register.
  - Divide: restoring step on a remainder/quotient register pair.
- Sign fix-up is applied on the CALC→DONE transition:
  - Product negated if its sign is negative.
  - Quotient negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of a.
- DONE: mdu_valid_o=1 for exactly this cycle, then IDLE unconditionally. A mdu_req_i seen in DONE is the same instruction and is not re-accepted.
- Stall: mdu_stall_req_o = mdu_req_i & ~mdu_kill_i & (state != DONE). It is combinational, so it is high in the acceptance cycle and drops in the valid cycle.
- Latency: request at cycle 0. Normal ops give valid at cycle XLEN+1 (33). Special cases give valid at cycle 1.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits. MULH is signed×signed, MULHSU is signed a × unsigned b, MULHU is unsigned×unsigned.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Divide by zero: quotient=all ones, remainder=a, for both signed and unsigned ops.
- Signed overflow (0x8000_0000 / -1): quotient=0x8000_0000, remainder=0.
- Kill: in any state, mdu_kill_i=1 forces IDLE next cycle with no valid pulse. Kill in DONE suppresses nothing already issued, since valid is asserted in the same cycle. Kill with a concurrent req in IDLE: the request is not accepted.
- Reset mid-operation: return to IDLE with all reset values, and no valid pulse afterward.
- mdu_result_o holds its last value outside DONE. The bench must check it only when mdu_valid_o=1.

Decomposition:
- miriscv_mdu_pkg holds MDU_OP_W=3, the opcode localparams (MDU_MUL=0 … MDU_REMU=7) and the FSM state enum.
- The decoder imports the same package.
- No sub-module: the shift-add and restoring-divide datapaths share the one 2*XLEN shift register and counter inside miriscv_mdu.

Test Plan:
- MUL: a=7, b=-3 (0xFFFF_FFFD) → valid at cycle 33, result=0xFFFF_FFEB; stall high cycles 0–32.
- MULH/MULHSU/MULHU with a=0x8000_0000, b=0xFFFF_FFFF → 0x0000_0000 / 0x8000_0000 / 0x7FFF_FFFF.
- DIV -7/2 → 0xFFFF_FFFD; REM -7/2 → 0xFFFF_FFFF; DIVU 0xFFFF_FFFF/16 → 0x0FFF_FFFF; REMU → 0xF.
- Special cases, each with valid at cycle 1:
  - DIVU 5/0 → 0xFFFF_FFFF; REM 5/0 → 5.
  - DIV 0x8000_0000/-1 → 0x8000_0000; REM → 0.
- Kill at cycle 10 of a DIV → IDLE at cycle 11, no valid; an immediate new MUL 3×4 → 12 at cycle 33 after its request.
- rstn_i=0 at cycle 5 of a MULHU → all outputs at reset values, no valid pulse afterward; a back-to-back request issued the cycle after DONE is accepted normally.
